// File: rtl/rggen_rtl_pkg.sv
// Shared rggen bus definitions used by bus producers, splitters and bridges.
//
// Contents:
//   rggen_status                 - response status returned with bus ready
//   RGGEN_ACCESS_DATA_BIT        - access bit that marks a write
//   RGGEN_ACCESS_NON_POSTED_BIT  - access bit that marks a request expecting a real response
//   RGGEN_READ / RGGEN_WRITE / RGGEN_POSTED_WRITE - legal access encodings
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY   = 2'b00,
    RGGEN_EXOKAY = 2'b01,
    RGGEN_SLVERR = 2'b10,
    RGGEN_DECERR = 2'b11
  } rggen_status;

  localparam int RGGEN_ACCESS_DATA_BIT       = 0;
  localparam int RGGEN_ACCESS_NON_POSTED_BIT = 1;

  localparam logic [1:0] RGGEN_READ         = 2'b10;
  localparam logic [1:0] RGGEN_WRITE        = 2'b11;
  localparam logic [1:0] RGGEN_POSTED_WRITE = 2'b01;

endpackage

// File: rtl/rggen_axi4lite_bridge_timer.sv
// Response-phase watchdog for the rggen AXI4-Lite bridge.
//
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   clear      - hold the count at zero (bridge is not waiting for a response)
//   enable     - count one more cycle without a response
//   expired    - count has reached TIMEOUT_CYCLES
//
// With TIMEOUT_CYCLES = 0 there is no counter at all and expired is tied low.
module rggen_axi4lite_bridge_timer #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT_CYCLES > 0) begin : g_timer
    localparam int                     COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] LIMIT       = COUNT_WIDTH'(TIMEOUT_CYCLES);

    logic [COUNT_WIDTH-1:0] count;

    // Counts waiting cycles; sticks at the limit so a slow response can never
    // wrap the counter back into a non-expired value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count <= '0;
      end else if (clear) begin
        count <= '0;
      end else if (enable && (count != LIMIT)) begin
        count <= count + COUNT_WIDTH'(1);
      end
    end

    assign expired = (count == LIMIT);
  end else begin : g_no_timer
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, clear, enable};
    assign expired       = 1'b0;
  end

endmodule

// File: rtl/rggen_axi4lite_bridge_ext.sv
// rggen bus to AXI4-Lite master bridge with posted writes, response timeout
// and response draining.
//
// One rggen request is converted at a time:
//   write / posted write -> AW + W (either order), then B
//   read                 -> AR, then R
// A posted write is acknowledged right after AW/W; its B response is absorbed
// in DRAIN_B. A timed-out request is acknowledged with SLVERR and its late
// response is absorbed in DRAIN_B/DRAIN_R, so every AXI transaction issued is
// matched by exactly one accepted response.
//
// Ports:
//   i_clk, i_rst_n                   - clock, asynchronous active-low reset
//   i_bus_*                          - rggen request (held until o_bus_ready)
//   o_bus_ready/status/read_data     - rggen completion (one-cycle pulse)
//   o_aw*/i_awready, o_w*/i_wready   - AXI write address and data channels
//   i_b*/o_bready                    - AXI write response channel
//   o_ar*/i_arready                  - AXI read address channel
//   i_r*/o_rready                    - AXI read data channel
module rggen_axi4lite_bridge_ext
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int BUS_WIDTH      = 32,
  parameter int ID_WIDTH       = 1,
  parameter int ID_VALUE       = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_bus_valid,
  input  logic [1:0]               i_bus_access,
  input  logic [ADDRESS_WIDTH-1:0] i_bus_address,
  input  logic [BUS_WIDTH-1:0]     i_bus_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_bus_strobe,
  output logic                     o_bus_ready,
  output logic [1:0]               o_bus_status,
  output logic [BUS_WIDTH-1:0]     o_bus_read_data,
  output logic                     o_awvalid,
  input  logic                     i_awready,
  output logic [ID_WIDTH-1:0]      o_awid,
  output logic [ADDRESS_WIDTH-1:0] o_awaddr,
  output logic [2:0]               o_awprot,
  output logic                     o_wvalid,
  input  logic                     i_wready,
  output logic [BUS_WIDTH-1:0]     o_wdata,
  output logic [BUS_WIDTH/8-1:0]   o_wstrb,
  input  logic                     i_bvalid,
  output logic                     o_bready,
  input  logic [ID_WIDTH-1:0]      i_bid,
  input  logic [1:0]               i_bresp,
  output logic                     o_arvalid,
  input  logic                     i_arready,
  output logic [ID_WIDTH-1:0]      o_arid,
  output logic [ADDRESS_WIDTH-1:0] o_araddr,
  output logic [2:0]               o_arprot,
  input  logic                     i_rvalid,
  output logic                     o_rready,
  input  logic [ID_WIDTH-1:0]      i_rid,
  input  logic [BUS_WIDTH-1:0]     i_rdata,
  input  logic [1:0]               i_rresp
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_B,
    WAIT_R,
    POSTED_ACK,
    DRAIN_B,
    DRAIN_R
  } state_e;

  state_e state;
  state_e state_next;

  logic aw_done;
  logic w_done;
  logic ar_done;

  logic is_write;
  logic is_posted;
  logic in_request;
  logic aw_complete;
  logic w_complete;
  logic ar_complete;
  logic write_issued;
  logic read_issued;
  logic timer_clear;
  logic timer_enable;
  logic timer_expired;

  // IDs are constant, so the returned IDs carry no information.
  logic unused_id;
  assign unused_id = ^{i_bid, i_rid};

  assign is_write   = i_bus_access[RGGEN_ACCESS_DATA_BIT];
  assign is_posted  = is_write && !i_bus_access[RGGEN_ACCESS_NON_POSTED_BIT];
  assign in_request = (state == IDLE);

  assign o_awid   = ID_WIDTH'(ID_VALUE);
  assign o_arid   = ID_WIDTH'(ID_VALUE);
  assign o_awprot = '0;
  assign o_arprot = '0;
  assign o_awaddr = i_bus_address;
  assign o_araddr = i_bus_address;
  assign o_wdata  = i_bus_write_data;
  assign o_wstrb  = i_bus_strobe;

  // Valids come only from the held request and the done flags, never from a
  // ready, so the bridge cannot form a combinational loop with the slave.
  assign o_awvalid = in_request && i_bus_valid &&  is_write && !aw_done;
  assign o_wvalid  = in_request && i_bus_valid &&  is_write && !w_done;
  assign o_arvalid = in_request && i_bus_valid && !is_write && !ar_done;

  // A channel counts as complete once its handshake happened earlier or is
  // happening now; the request phase ends when every needed channel is done.
  assign aw_complete  = aw_done || (o_awvalid && i_awready);
  assign w_complete   = w_done  || (o_wvalid  && i_wready);
  assign ar_complete  = ar_done || (o_arvalid && i_arready);
  assign write_issued = in_request && i_bus_valid &&  is_write && aw_complete && w_complete;
  assign read_issued  = in_request && i_bus_valid && !is_write && ar_complete;

  // Done flags remember a handshake that finished before its partner
  // channel; they are cleared as soon as the request phase is left.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      ar_done <= 1'b0;
    end else if (!in_request || write_issued || read_issued) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      ar_done <= 1'b0;
    end else begin
      aw_done <= aw_complete;
      w_done  <= w_complete;
      ar_done <= ar_complete;
    end
  end

  // The watchdog only runs while a real response is awaited; it restarts
  // from zero on every entry into WAIT_B/WAIT_R.
  assign timer_clear  = (state != WAIT_B) && (state != WAIT_R);
  assign timer_enable = ((state == WAIT_B) && !i_bvalid) ||
                        ((state == WAIT_R) && !i_rvalid);

  rggen_axi4lite_bridge_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and response-side outputs. A response that shows up in the
  // same cycle as the timeout takes priority, so no drain is needed then.
  always_comb begin
    state_next      = state;
    o_bready        = 1'b0;
    o_rready        = 1'b0;
    o_bus_ready     = 1'b0;
    o_bus_status    = RGGEN_OKAY;
    o_bus_read_data = '0;
    case (state)
      IDLE: begin
        if (write_issued) begin
          state_next = is_posted ? POSTED_ACK : WAIT_B;
        end else if (read_issued) begin
          state_next = WAIT_R;
        end
      end
      WAIT_B: begin
        o_bready = 1'b1;
        if (i_bvalid) begin
          o_bus_ready  = 1'b1;
          o_bus_status = i_bresp;
          state_next   = IDLE;
        end else if (timer_expired) begin
          o_bus_ready  = 1'b1;
          o_bus_status = RGGEN_SLVERR;
          state_next   = DRAIN_B;
        end
      end
      WAIT_R: begin
        o_rready = 1'b1;
        if (i_rvalid) begin
          o_bus_ready     = 1'b1;
          o_bus_status    = i_rresp;
          o_bus_read_data = i_rdata;
          state_next      = IDLE;
        end else if (timer_expired) begin
          o_bus_ready  = 1'b1;
          o_bus_status = RGGEN_SLVERR;
          state_next   = DRAIN_R;
        end
      end
      POSTED_ACK: begin
        o_bus_ready = 1'b1;
        state_next  = DRAIN_B;
      end
      DRAIN_B: begin
        o_bready = 1'b1;
        if (i_bvalid) begin
          state_next = IDLE;
        end
      end
      DRAIN_R: begin
        o_rready = 1'b1;
        if (i_rvalid) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rggen_axi4lite_bridge_ext.sv
module tb_rggen_axi4lite_bridge_ext;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int IDW = 1;
  localparam int IDV = 1;
  localparam int TO  = 8;

  logic          clk;
  logic          rst_n;
  logic          bus_valid;
  logic [1:0]    bus_access;
  logic [AW-1:0] bus_address;
  logic [DW-1:0] bus_write_data;
  logic [SW-1:0] bus_strobe;
  logic          bus_ready;
  logic [1:0]    bus_status;
  logic [DW-1:0] bus_read_data;
  logic          awvalid, awready;
  logic [IDW-1:0] awid;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          wvalid, wready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          bvalid, bready;
  logic [IDW-1:0] bid;
  logic [1:0]    bresp;
  logic          arvalid, arready;
  logic [IDW-1:0] arid;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          rvalid, rready;
  logic [IDW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;

  int total = 0;
  int bad   = 0;

  rggen_axi4lite_bridge_ext #(
    .ADDRESS_WIDTH  (AW),
    .BUS_WIDTH      (DW),
    .ID_WIDTH       (IDW),
    .ID_VALUE       (IDV),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_bus_valid      (bus_valid),
    .i_bus_access     (bus_access),
    .i_bus_address    (bus_address),
    .i_bus_write_data (bus_write_data),
    .i_bus_strobe     (bus_strobe),
    .o_bus_ready      (bus_ready),
    .o_bus_status     (bus_status),
    .o_bus_read_data  (bus_read_data),
    .o_awvalid        (awvalid),
    .i_awready        (awready),
    .o_awid           (awid),
    .o_awaddr         (awaddr),
    .o_awprot         (awprot),
    .o_wvalid         (wvalid),
    .i_wready         (wready),
    .o_wdata          (wdata),
    .o_wstrb          (wstrb),
    .i_bvalid         (bvalid),
    .o_bready         (bready),
    .i_bid            (bid),
    .i_bresp          (bresp),
    .o_arvalid        (arvalid),
    .i_arready        (arready),
    .o_arid           (arid),
    .o_araddr         (araddr),
    .o_arprot         (arprot),
    .i_rvalid         (rvalid),
    .o_rready         (rready),
    .i_rid            (rid),
    .i_rdata          (rdata),
    .i_rresp          (rresp)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch with tag and values.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drops every bench-driven input to its quiet value.
  task automatic clearInputs();
    bus_valid      = 1'b0;
    bus_access     = 2'b00;
    bus_address    = '0;
    bus_write_data = '0;
    bus_strobe     = '0;
    awready        = 1'b0;
    wready         = 1'b0;
    bvalid         = 1'b0;
    bid            = '0;
    bresp          = 2'b00;
    arready        = 1'b0;
    rvalid         = 1'b0;
    rid            = '0;
    rdata          = '0;
    rresp          = 2'b00;
  endtask

  // Runs one bus request against a scripted AXI slave. The slave raises
  // AW/W/AR ready after awd/wd/ard cycles and answers rspd cycles after the
  // cycle following the last request handshake. Expected completion cycle,
  // status and response-acceptance cycle come from the bridge's timing rules.
  task automatic applyStimulus(input string name, input logic [1:0] acc, input logic [15:0] addr,
                               input logic [31:0] wdat, input logic [3:0] strb, input int awd,
                               input int wd, input int ard, input int rspd, input logic [1:0] resp,
                               input logic [31:0] rdat);
    bit          isWrite;
    bit          isPosted;
    bit          timedOut;
    int          entry;
    int          expReady;
    int          expAccept;
    logic [1:0]  expStatus;
    int          awCnt = 0, wCnt = 0, arCnt = 0, respCnt = 0, readyCnt = 0;
    int          readyCyc = -1, acceptCyc = -1, lastHs = -1;
    logic [1:0]  gotStatus = 2'bxx;
    logic [31:0] gotRdata  = 'x;
    bit          addrOk = 1, dataOk = 1, constOk = 1, finished = 0;

    isWrite  = acc[0];
    isPosted = (acc == 2'b01);
    entry    = (isWrite ? ((awd > wd) ? awd : wd) : ard) + 1;
    if (isPosted) begin
      expReady  = entry;
      expStatus = 2'b00;
      expAccept = (rspd > 1) ? entry + rspd : entry + 1;
      timedOut  = 0;
    end else if (rspd <= TO) begin
      expReady  = entry + rspd;
      expStatus = resp;
      expAccept = entry + rspd;
      timedOut  = 0;
    end else begin
      expReady  = entry + TO;
      expStatus = 2'b10;
      expAccept = entry + rspd;
      timedOut  = 1;
    end

    for (int k = 0; k < 100 && !finished; k++) begin
      @(negedge clk);
      bus_valid      = (readyCnt == 0);
      bus_access     = acc;
      bus_address    = addr;
      bus_write_data = wdat;
      bus_strobe     = strb;
      awready        = (k >= awd);
      wready         = (k >= wd);
      arready        = (k >= ard);
      bvalid         = 1'b0;
      rvalid         = 1'b0;
      if (lastHs >= 0 && k >= lastHs + 1 + rspd && respCnt == 0) begin
        if (isWrite) begin
          bvalid = 1'b1;
          bresp  = resp;
        end else begin
          rvalid = 1'b1;
          rresp  = resp;
          rdata  = rdat;
        end
      end
      #1;
      if (awvalid && awready) begin
        awCnt++;
        if (awaddr !== addr) addrOk = 0;
        if (awid !== IDW'(IDV) || awprot !== 3'b000) constOk = 0;
      end
      if (wvalid && wready) begin
        wCnt++;
        if (wdata !== wdat || wstrb !== strb) dataOk = 0;
      end
      if (arvalid && arready) begin
        arCnt++;
        if (araddr !== addr) addrOk = 0;
        if (arid !== IDW'(IDV) || arprot !== 3'b000) constOk = 0;
      end
      if (lastHs < 0 && (isWrite ? (awCnt > 0 && wCnt > 0) : (arCnt > 0))) lastHs = k;
      if (bus_ready) begin
        readyCnt++;
        if (readyCyc < 0) begin
          readyCyc  = k;
          gotStatus = bus_status;
          gotRdata  = bus_read_data;
        end
      end
      if ((bvalid && bready) || (rvalid && rready)) begin
        respCnt++;
        acceptCyc = k;
      end
      if (respCnt > 0 && readyCnt > 0) finished = 1;
    end

    @(negedge clk);
    clearInputs();
    #1;
    checkOutput({name, ".bound"},     32'(finished), 32'd1);
    checkOutput({name, ".readyCnt"},  readyCnt, 1);
    checkOutput({name, ".readyCyc"},  readyCyc, expReady);
    checkOutput({name, ".status"},    32'(gotStatus), 32'(expStatus));
    if (!isWrite && !timedOut) checkOutput({name, ".rdata"}, gotRdata, rdat);
    checkOutput({name, ".awCnt"},     awCnt, isWrite ? 1 : 0);
    checkOutput({name, ".wCnt"},      wCnt, isWrite ? 1 : 0);
    checkOutput({name, ".arCnt"},     arCnt, isWrite ? 0 : 1);
    checkOutput({name, ".fields"},    32'({addrOk, dataOk, constOk}), 32'b111);
    checkOutput({name, ".respCnt"},   respCnt, 1);
    checkOutput({name, ".acceptCyc"}, acceptCyc, expAccept);
    checkOutput({name, ".idle"},      32'({awvalid, wvalid, arvalid, bready, rready, bus_ready}), 32'd0);
  endtask

  initial begin
    int          bHs, arFirst, arHs, wrReadyCyc, rdReadyCyc;
    bit          wrDone, rdDone;
    logic [1:0]  wrStatus, rdStatus;
    logic [31:0] rdValue;

    rst_n = 1'b0;
    clearInputs();
    #1;
    // Reset state.
    checkOutput("reset.valids",  32'({awvalid, wvalid, arvalid}), 32'd0);
    checkOutput("reset.readies", 32'({bready, rready, bus_ready}), 32'd0);
    checkOutput("reset.status",  32'(bus_status), 32'd0);
    checkOutput("reset.ids",     32'({awid, arid}), 32'({IDW'(IDV), IDW'(IDV)}));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the bring-up plan.
    applyStimulus("wrAwFirst", 2'b11, 16'h0010, 32'hDEADBEEF, 4'hF, 0, 2, 0, 3, 2'b00, 32'h0);
    applyStimulus("rdSlverr",  2'b10, 16'h0024, 32'h0, 4'h0, 0, 0, 0, 0, 2'b10, 32'h12345678);
    applyStimulus("rdTimeout", 2'b10, 16'h0030, 32'h0, 4'h0, 0, 0, 0, 20, 2'b00, 32'hAAAA5555);
    applyStimulus("rdEdge",    2'b10, 16'h0034, 32'h0, 4'h0, 0, 0, 1, TO, 2'b01, 32'h0BADF00D);
    applyStimulus("wrTimeout", 2'b11, 16'h0040, 32'h01020304, 4'h5, 1, 0, 0, TO + 1, 2'b00, 32'h0);
    applyStimulus("wrEdge",    2'b11, 16'h0044, 32'h55AA55AA, 4'hA, 0, 0, 0, TO, 2'b11, 32'h0);
    applyStimulus("postedFast", 2'b01, 16'h0050, 32'h11223344, 4'h3, 0, 0, 0, 0, 2'b10, 32'h0);

    // Posted write whose B arrives late, with a read queued right behind it:
    // the read must not issue before the posted write's B is absorbed.
    wrDone = 0; rdDone = 0; bHs = -1; arFirst = -1; arHs = -1;
    wrReadyCyc = -1; rdReadyCyc = -1; wrStatus = 2'bxx; rdStatus = 2'bxx; rdValue = 'x;
    for (int k = 0; k < 40 && !rdDone; k++) begin
      @(negedge clk);
      if (!wrDone) begin
        bus_valid = 1'b1; bus_access = 2'b01; bus_address = 16'h0060;
        bus_write_data = 32'hFEEDFACE; bus_strobe = 4'hF;
      end else begin
        bus_valid = 1'b1; bus_access = 2'b10; bus_address = 16'h0064;
      end
      awready = 1'b1; wready = 1'b1; arready = 1'b1;
      bvalid  = (k >= 6 && bHs < 0);
      bresp   = 2'b11;
      rvalid  = (arHs >= 0 && k > arHs);
      rresp   = 2'b00;
      rdata   = 32'hCAFEF00D;
      #1;
      if (arvalid && arFirst < 0) arFirst = k;
      if (arvalid && arready) arHs = k;
      if (bvalid && bready) bHs = k;
      if (bus_ready) begin
        if (!wrDone) begin
          wrDone = 1; wrReadyCyc = k; wrStatus = bus_status;
        end else begin
          rdDone = 1; rdReadyCyc = k; rdStatus = bus_status; rdValue = bus_read_data;
        end
      end
    end
    @(negedge clk);
    clearInputs();
    checkOutput("queued.bound",      32'(rdDone), 32'd1);
    checkOutput("queued.wrReadyCyc", wrReadyCyc, 1);
    checkOutput("queued.wrStatus",   32'(wrStatus), 32'd0);
    checkOutput("queued.bHs",        bHs, 6);
    checkOutput("queued.arFirst",    arFirst, 7);
    checkOutput("queued.rdReadyCyc", rdReadyCyc, 8);
    checkOutput("queued.rdStatus",   32'(rdStatus), 32'd0);
    checkOutput("queued.rdData",     rdValue, 32'hCAFEF00D);

    // Reset while waiting for B: the producer is reset alongside the bridge.
    @(negedge clk);
    bus_valid = 1'b1; bus_access = 2'b11; bus_address = 16'h0070;
    bus_write_data = 32'h0F0F0F0F; bus_strobe = 4'hF;
    awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rst.waitB", 32'({bready, bus_ready}), 32'b10);
    rst_n = 1'b0;
    bus_valid = 1'b0;
    #1;
    checkOutput("rst.outputs", 32'({awvalid, wvalid, arvalid, bready, rready, bus_ready}), 32'd0);
    checkOutput("rst.status",  32'(bus_status), 32'd0);
    @(negedge clk);
    clearInputs();
    rst_n = 1'b1;
    applyStimulus("afterRst", 2'b11, 16'h0074, 32'h13579BDF, 4'hC, 0, 0, 0, 1, 2'b00, 32'h0);

    // Randomised requests, delays and responses, including both sides of
    // the timeout boundary.
    for (int i = 0; i < 25; i++) begin
      logic [1:0] acc;
      int         sel;
      sel = $urandom_range(0, 2);
      acc = (sel == 0) ? 2'b10 : ((sel == 1) ? 2'b11 : 2'b01);
      applyStimulus($sformatf("rand%0d", i), acc, 16'($urandom_range(0, 16'hFFFF)), $urandom,
                    4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 11), 2'($urandom_range(0, 3)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
